// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: steps one 1-bit full-adder cell across WIDTH
// cycles. Latency is traded for area: one fa, two operand shift registers,
// a result shift register and a single carry flop.

// 1-bit full adder cell shared by the serial datapath
module fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    // Counter must be able to hold WIDTH so it never wraps inside one add
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] opa, opb, res;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             fa_s, fa_co;
    logic [WIDTH-1:0] res_nxt;

    fa u_fa (
        .a  (opa[0]),
        .b  (opb[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    // New sum bit enters at the MSB; after WIDTH shifts bit 0 lands at LSB
    assign res_nxt = WIDTH'({fa_s, res} >> 1);

    // Control FSM and serial datapath; sum/cout only load on entry to DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            cnt   <= '0;
            carry <= 1'b0;
            opa   <= '0;
            opb   <= '0;
            res   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        opa   <= a;
                        opb   <= b;
                        carry <= cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    res   <= res_nxt;
                    opa   <= opa >> 1;
                    opb   <= opb >> 1;
                    carry <= fa_co;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        sum   <= res_nxt;
                        cout  <= fa_co;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;

    typedef struct {
        logic [8:0] res;
        int         cyc;
    } exp_t;

    int ntests = 0;
    int nfail  = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic       start8 = 1'b0, cin8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;

    serial_add_ctrl #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    logic start1 = 1'b0, cin1 = 1'b0;
    logic a1 = 1'b0, b1 = 1'b0;
    logic busy1, done1, cout1, sum1;

    serial_add_ctrl #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    exp_t       q8[$];
    exp_t       q1[$];
    logic [8:0] last8 = '0;

    always @(negedge clk) begin
        if (!rst && done8) begin
            if (q8.size() == 0) begin
                ntests++; nfail++;
                $error("FAIL done8_unexpected observed=done expected=none");
            end else begin
                exp_t e;
                e = q8.pop_front();
                ntests++;
                if ({cout8, sum8} !== e.res) begin
                    nfail++;
                    $error("FAIL res8 observed=%0h expected=%0h", {cout8, sum8}, e.res);
                end
                ntests++;
                if (cyc !== e.cyc) begin
                    nfail++;
                    $error("FAIL lat8 observed=%0d expected=%0d", cyc, e.cyc);
                end
            end
        end
        if (!rst && done1) begin
            if (q1.size() == 0) begin
                ntests++; nfail++;
                $error("FAIL done1_unexpected observed=done expected=none");
            end else begin
                exp_t e;
                e = q1.pop_front();
                ntests++;
                if ({cout1, sum1} !== e.res[1:0]) begin
                    nfail++;
                    $error("FAIL res1 observed=%0h expected=%0h", {cout1, sum1}, e.res[1:0]);
                end
                ntests++;
                if (cyc !== e.cyc) begin
                    nfail++;
                    $error("FAIL lat1 observed=%0d expected=%0d", cyc, e.cyc);
                end
            end
        end
    end

    function automatic exp_t mk(input logic [8:0] r, input int c);
        exp_t e;
        e.res = r;
        e.cyc = c;
        return e;
    endfunction

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c);
        int         busyc = 0;
        bit         seen  = 0;
        logic [8:0] r;
        r = {1'b0, a} + {1'b0, b} + {8'b0, c};
        @(negedge clk);
        a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
        q8.push_back(mk(r, cyc + 9));
        @(negedge clk);
        start8 = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (done8) seen = 1;
            else begin
                if (busy8) busyc++;
                ntests++;
                if ({cout8, sum8} !== last8) begin
                    nfail++;
                    $error("FAIL hold8 observed=%0h expected=%0h", {cout8, sum8}, last8);
                end
                @(negedge clk);
            end
        end
        ntests++;
        if (seen !== 1'b1) begin
            nfail++;
            $error("FAIL seen8 observed=%0d expected=1", seen);
        end
        ntests++;
        if (busyc !== 8) begin
            nfail++;
            $error("FAIL busy8_cnt observed=%0d expected=8", busyc);
        end
        last8 = r;
    endtask

    task automatic wait_done8(input string tag);
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (done8) seen = 1;
        end
        ntests++;
        if (seen !== 1'b1) begin
            nfail++;
            $error("FAIL %s observed=%0d expected=1", tag, seen);
        end
    endtask

    task automatic run1(input logic a, input logic b, input logic c);
        bit         seen = 0;
        logic [8:0] r;
        r = {8'b0, a} + {8'b0, b} + {8'b0, c};
        @(negedge clk);
        a1 = a; b1 = b; cin1 = c; start1 = 1'b1;
        q1.push_back(mk(r, cyc + 2));
        @(negedge clk);
        start1 = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            if (done1) seen = 1;
            else @(negedge clk);
        end
        ntests++;
        if (seen !== 1'b1) begin
            nfail++;
            $error("FAIL seen1 observed=%0d expected=1", seen);
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        ntests++;
        if (busy8 !== 1'b0) begin nfail++; $error("FAIL rst_busy8 observed=%0h expected=0", busy8); end
        ntests++;
        if (done8 !== 1'b0) begin nfail++; $error("FAIL rst_done8 observed=%0h expected=0", done8); end
        ntests++;
        if ({cout8, sum8} !== 9'h000) begin nfail++; $error("FAIL rst_res8 observed=%0h expected=0", {cout8, sum8}); end
        ntests++;
        if (busy1 !== 1'b0) begin nfail++; $error("FAIL rst_busy1 observed=%0h expected=0", busy1); end
        ntests++;
        if ({cout1, sum1} !== 2'b00) begin nfail++; $error("FAIL rst_res1 observed=%0h expected=0", {cout1, sum1}); end
        rst = 1'b0;

        run8(8'h5A, 8'h3C, 1'b0);
        run8(8'hFF, 8'h01, 1'b0);
        run8(8'hFF, 8'hFF, 1'b1);

        @(negedge clk);
        a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0; start8 = 1'b1;
        q8.push_back(mk(9'h033, cyc + 9));
        begin
            bit seen = 0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge clk);
                if (done8) seen = 1;
                else begin
                    ntests++;
                    if (busy8 !== 1'b1) begin
                        nfail++;
                        $error("FAIL busy8_held observed=%0h expected=1", busy8);
                    end
                    a8 = 8'($urandom); b8 = 8'($urandom);
                end
            end
            start8 = 1'b0;
            ntests++;
            if (seen !== 1'b1) begin
                nfail++;
                $error("FAIL seen8_held observed=%0d expected=1", seen);
            end
        end
        last8 = 9'h033;

        @(negedge clk);
        a8 = 8'h44; b8 = 8'h55; cin8 = 1'b1; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        ntests++;
        if (busy8 !== 1'b1) begin nfail++; $error("FAIL busy8_prerst observed=%0h expected=1", busy8); end
        rst = 1'b1;
        @(negedge clk);
        ntests++;
        if (busy8 !== 1'b0) begin nfail++; $error("FAIL abort_busy8 observed=%0h expected=0", busy8); end
        ntests++;
        if (done8 !== 1'b0) begin nfail++; $error("FAIL abort_done8 observed=%0h expected=0", done8); end
        ntests++;
        if ({cout8, sum8} !== 9'h000) begin nfail++; $error("FAIL abort_res8 observed=%0h expected=0", {cout8, sum8}); end
        rst = 1'b0;
        last8 = '0;
        repeat (12) @(negedge clk);
        run8(8'h77, 8'h19, 1'b1);

        @(negedge clk);
        a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; start8 = 1'b1;
        q8.push_back(mk(9'h100, cyc + 9));
        @(negedge clk);
        start8 = 1'b0;
        wait_done8("seen8_b2b_first");
        a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0; start8 = 1'b1;
        q8.push_back(mk(9'h003, cyc + 9));
        @(negedge clk);
        start8 = 1'b0;
        ntests++;
        if (busy8 !== 1'b1) begin nfail++; $error("FAIL b2b_busy8 observed=%0h expected=1", busy8); end
        wait_done8("seen8_b2b_second");
        @(negedge clk);

        for (int k = 0; k < 8; k++) begin
            logic [2:0] v;
            v = 3'(k);
            run1(v[2], v[1], v[0]);
        end

        repeat (3) @(negedge clk);
        ntests++;
        if (q8.size() !== 0) begin nfail++; $error("FAIL q8_drained observed=%0d expected=0", q8.size()); end
        ntests++;
        if (q1.size() !== 0) begin nfail++; $error("FAIL q1_drained observed=%0d expected=0", q1.size()); end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench time limit reached");
    end

endmodule
